// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - bimodal branch history table with ID-stage mispredict resolve
// Ports:
//   clk, rst                 clock, async active-high reset
//   if_pc, if_ir             fetch-stage PC and instruction
//   pred_taken, pred_target  fetch-stage prediction and branch target
//   id_valid, id_pc, id_ir   ID-stage instruction
//   id_pred_taken            prediction carried down with the ID instruction
//   branch_yes, stall        comparator outcome, ID stall
//   flush, redirect_pc       mispredict squash and corrected next PC
//   branch_count             resolved branches
//   mispredict_count         resolved mispredicts
module branch_predictor_bht #(
    parameter int         INDEX_BITS  = 6,
    parameter logic [1:0] RESET_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_ir,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_ir,
    input  logic        id_pred_taken,
    input  logic        branch_yes,
    input  logic        stall,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // 2-bit saturating counters; bit 1 is the taken prediction
    logic [1:0] bht [ENTRIES];

    function automatic logic is_br(input logic [5:0] op);
        return (op >= 6'h08) && (op <= 6'h0D);
    endfunction

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] id_idx;
    logic [31:0]           if_off;
    logic [31:0]           id_off;
    logic                  res;
    logic                  mis;
    logic                  unused_ir_bits;

    assign unused_ir_bits = ^{if_ir[25:16], id_ir[25:16]};

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign id_idx = id_pc[INDEX_BITS+1:2];

    // word offset, sign-extended and scaled by 4
    assign if_off = {{14{if_ir[15]}}, if_ir[15:0], 2'b00};
    assign id_off = {{14{id_ir[15]}}, id_ir[15:0], 2'b00};

    assign pred_target = if_pc + 32'd4 + if_off;

    // IF reads the table before any same-cycle training lands (no bypass)
    assign pred_taken = !rst && is_br(if_ir[31:26]) && bht[if_idx][1];

    // gating with rst keeps a resolve at reset release from acting early
    assign res   = !rst && id_valid && is_br(id_ir[31:26]) && !stall;
    assign mis   = res && (branch_yes != id_pred_taken);
    assign flush = mis;

    always_comb begin
        redirect_pc = 32'd0;
        if (mis) begin
            redirect_pc = branch_yes ? (id_pc + 32'd4 + id_off) : (id_pc + 32'd4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= RESET_STATE;
            end
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else if (res) begin
            branch_count <= branch_count + 32'd1;
            if (mis) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (branch_yes) begin
                if (bht[id_idx] != 2'b11) begin
                    bht[id_idx] <= bht[id_idx] + 2'b01;
                end
            end else begin
                if (bht[id_idx] != 2'b00) begin
                    bht[id_idx] <= bht[id_idx] - 2'b01;
                end
            end
        end
    end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Fetch-side branch predictor and ID-stage mispredict resolver for the 32-bit pipelined core. In IF it predicts direction and target for branch opcodes 0x08–0x0D using a table of 2-bit saturating counters. In ID it takes the branch comparator's resolved `branch_yes`, trains the table and raises a flush/redirect when the prediction carried down the pipe was wrong. It sits between the PC/fetch logic and the ID-stage branch comparator.

## Interface
- `INDEX_BITS`, default 6 — table has 2^INDEX_BITS entries, indexed by `pc[INDEX_BITS+1:2]`.
- `RESET_STATE`, default 2'b01 — value loaded into every entry on reset (weakly not-taken).
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `if_pc`  in  32  — PC of the instruction in fetch.
- `if_ir`  in  32  — instruction word in fetch.
- `pred_taken`  out  1  — IF prediction; 1 = redirect fetch to `pred_target`.
- `pred_target`  out  32  — `if_pc + 4 + (sign_extend(if_ir[15:0]) << 2)`.
- `id_valid`  in  1  — ID holds a real instruction, not a bubble.
- `id_pc`  in  32  — PC of the ID instruction.
- `id_ir`  in  32  — ID instruction word.
- `id_pred_taken`  in  1  — `pred_taken` value piped along with this instruction.
- `branch_yes`  in  1  — comparator outcome for the ID instruction.
- `stall`  in  1  — ID stalled this cycle; comparator operands are not final.
- `flush`  out  1  — mispredict; the IF instruction must be squashed.
- `redirect_pc`  out  32  — correct next PC when `flush` = 1, else 0.
- `branch_count`  out  32  — number of resolved branches.
- `mispredict_count`  out  32  — number of resolved mispredicts.

## Operation
- Branch decode: `is_br(ir)` = `ir[31:26]` in {0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D}. All other opcodes are never predicted or trained.
- Counter encoding: 00 strong not-taken, 01 weak NT, 10 weak taken, 11 strong taken. Predict taken = bit 1.
- IF: `pred_taken = is_br(if_ir) & table[if_idx][1]`. `pred_target` is always driven and wraps modulo 2^32.
- Resolve condition: `res = id_valid & is_br(id_ir) & !stall`.
- Mispredict: `mis = res & (branch_yes != id_pred_taken)`. `flush = mis`.
- Redirect when `flush` = 1:
  - actual taken: `redirect_pc = id_pc + 4 + (sign_extend(id_ir[15:0]) << 2)`.
  - actual not-taken: `redirect_pc = id_pc + 4`.
  - All arithmetic is 32-bit and wraps.
- Training on `res`:
  - `branch_yes` = 1: entry increments, saturating at 11.
  - `branch_yes` = 0: entry decrements, saturating at 00.
- Statistics:
  - `branch_count` increments on every `res`.
  - `mispredict_count` increments on every `mis`.
  - Both wrap at 2^32.
- Aliasing: PCs with equal index bits share an entry. No tags.
- Stall: when `stall` = 1 there is no training, no count change and `flush` = 0, regardless of `branch_yes`.

## Timing
- `pred_taken`, `pred_target`, `flush` and `redirect_pc` are combinational from the current inputs and the current table state (zero latency).
- Table and counters update on the rising `clk` edge after `res`. A training result is visible to IF prediction from the next cycle.
- Same-cycle IF read and ID write to the same index: IF sees the pre-update value (no bypass).
- Reset (async, any time, including mid-resolve):
  - All entries go to `RESET_STATE`; both counters go to 0.
  - While `rst` = 1, `pred_taken` = 0, `flush` = 0 and `redirect_pc` = 0.
  - A resolve that coincides with reset release is ignored until the first edge with `rst` = 0.
- Each ID instruction is resolved at most once. The pipeline guarantees the post-flush ID slot arrives with `id_valid` = 0.

## Test plan
- Reset, then IF `beq` (op 0x08) at 0x100 → `pred_taken` = 0, `pred_target` = 0x104 + (imm<<2); both counters = 0.
- Two taken resolves at `id_pc` = 0x100 → entry goes 01→10→11; IF at 0x100 gives `pred_taken` = 1. A third taken resolve leaves the entry at 11. Three not-taken resolves take it to 00, then it stays at 00.
- `id_pc` = 0x100, imm = 0x0004, `id_pred_taken` = 0, `branch_yes` = 1 → `flush` = 1 and `redirect_pc` = 0x114 in the same cycle; `mispredict_count` = 1 after the edge. With `id_pred_taken` = 1 and `branch_yes` = 0 → `redirect_pc` = 0x104. Imm = 0xFFFF with `branch_yes` = 1 → `redirect_pc` = 0x100.
- Mispredicting resolve held with `stall` = 1 for 3 cycles → `flush` = 0 and no table or count change; release `stall` → a single flush, counts +1.
- Aliasing and same-cycle hazard (INDEX_BITS = 6): train 0x100 to 11 → IF at 0x200 predicts taken. Then resolve not-taken at 0x200 while IF reads 0x100 in the same cycle → IF sees the old value 11; the entry is 10 next cycle.
- Non-branch opcode (0x23) in IF with the entry at 11 → `pred_taken` = 0. The same opcode in ID with `branch_yes` = 1 → no training and no flush. Assert `rst` mid-resolve → `flush` drops immediately and all entries read as 01.
